// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of
// up to MAX_BURST beats into a shared FIFO write port.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic                      fifo_full_i,
    input  logic                      fifo_overflow_i,
    output logic                      fifo_wr_en_o,
    output logic [DATA_W-1:0]         fifo_wdata_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      err_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] owner_d;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;
    logic [IDX_W-1:0] cand;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_q;
    logic             found;
    logic             xfer;
    logic             owner_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            if (fifo_overflow_i) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        grant_o      = '0;
        req_ready_o  = '0;
        fifo_wr_en_o = 1'b0;
        fifo_wdata_o = '0;
        found        = 1'b0;
        cand         = '0;
        xfer         = 1'b0;
        owner_valid  = req_valid_i[owner_q];

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Search starts one past the previous owner and wraps.
                for (int i = 1; i <= NUM_REQ; i++) begin
                    cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
                    if (!found && req_valid_i[cand]) begin
                        found   = 1'b1;
                        owner_d = cand;
                    end
                end
                if (found) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (owner_q == IDX_W'(k)) begin
                        grant_o[k]     = 1'b1;
                        req_ready_o[k] = !fifo_full_i;
                        fifo_wdata_o   = req_data_i[k*DATA_W +: DATA_W];
                    end
                end
                xfer         = owner_valid && !fifo_full_i;
                fifo_wr_en_o = xfer;
                if (!owner_valid || (xfer && cnt_q == CNT_END)) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        // A reset cycle must never write, even if the FSM was mid-burst.
        if (rst_i) begin
            grant_o      = '0;
            req_ready_o  = '0;
            fifo_wr_en_o = 1'b0;
            fifo_wdata_o = '0;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (DATA_W=8, NUM_REQ=4, MAX_BURST=4).
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_overflow;
    logic        wr_en;
    logic [7:0]  wdata;
    logic [3:0]  grant;
    logic        err;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(
        .DATA_W   (8),
        .NUM_REQ  (4),
        .MAX_BURST(4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .fifo_full_i    (fifo_full),
        .fifo_overflow_i(fifo_overflow),
        .fifo_wr_en_o   (wr_en),
        .fifo_wdata_o   (wdata),
        .grant_o        (grant),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [3:0] g,
                            input logic [7:0] d);
        #1;
        chk({tag, " grant"}, 32'(grant), 32'(g));
        chk({tag, " wr_en"}, 32'(wr_en), 32'd1);
        chk({tag, " wdata"}, 32'(wdata), 32'(d));
    endtask

    task automatic chk_idle(input string tag);
        #1;
        chk({tag, " grant"}, 32'(grant), 32'd0);
        chk({tag, " ready"}, 32'(req_ready), 32'd0);
        chk({tag, " wr_en"}, 32'(wr_en), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = '0;
        req_data      = '0;
        fifo_full     = 1'b0;
        fifo_overflow = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset wdata", 32'(wdata), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        rst = 1'b0;

        // Single requester, 6 words through a 4-beat burst limit
        req_valid = 4'b0100;
        req_data[16 +: 8] = 8'h10;
        chk_idle("single pre");
        for (int b = 0; b < 4; b++) begin
            tick();
            req_data[16 +: 8] = 8'(8'h10 + b);
            chk_beat("single burst1", 4'b0100, 8'(8'h10 + b));
        end
        tick();
        req_data[16 +: 8] = 8'h14;
        chk_idle("single gap");
        tick();
        chk_beat("single burst2 b0", 4'b0100, 8'h14);
        tick();
        req_data[16 +: 8] = 8'h15;
        chk_beat("single burst2 b1", 4'b0100, 8'h15);
        tick();
        req_valid = 4'b0000;
        #1;
        chk("single drop wr_en", 32'(wr_en), 32'd0);
        tick();
        chk_idle("single end");

        // Round robin with everyone continuously valid
        rst = 1'b1;
        tick();
        chk_idle("rr reset");
        rst = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'hA3A2A1A0;
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) begin
                tick();
                chk_beat("rr beat", 4'(1 << (g % 4)), 8'(8'hA0 + (g % 4)));
            end
            tick();
            chk_idle("rr gap");
        end

        // Full backpressure mid-burst of requester 1
        req_valid = 4'b0010;
        req_data  = 32'h0000_3100;
        tick();
        chk_beat("full b0", 4'b0010, 8'h31);
        tick();
        req_data[8 +: 8] = 8'h32;
        chk_beat("full b1", 4'b0010, 8'h32);
        tick();
        req_data[8 +: 8] = 8'h33;
        fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("full stall wr_en", 32'(wr_en), 32'd0);
            chk("full stall ready", 32'(req_ready), 32'd0);
            chk("full stall grant", 32'(grant), 32'b0010);
            tick();
        end
        fifo_full = 1'b0;
        chk_beat("full b2", 4'b0010, 8'h33);
        tick();
        req_data[8 +: 8] = 8'h34;
        chk_beat("full b3", 4'b0010, 8'h34);
        tick();
        req_valid = 4'b0000;
        chk_idle("full end");
        chk("full err", 32'(err), 32'd0);

        // Requester 3 drops early, requester 0 follows via wrap
        req_valid = 4'b1001;
        req_data  = 32'h4000_0050;
        tick();
        chk_beat("drop b0", 4'b1000, 8'h40);
        tick();
        req_data[24 +: 8] = 8'h41;
        chk_beat("drop b1", 4'b1000, 8'h41);
        tick();
        req_valid = 4'b0001;
        #1;
        chk("drop wr_en", 32'(wr_en), 32'd0);
        tick();
        chk_idle("drop gap");
        tick();
        chk_beat("drop next", 4'b0001, 8'h50);
        tick();
        req_valid = 4'b0000;
        tick();
        chk_idle("drop end");

        // Reset in the middle of requester 1's burst
        req_valid = 4'b0011;
        req_data  = 32'h0000_6170;
        tick();
        chk_beat("rstmid b0", 4'b0010, 8'h61);
        tick();
        chk_beat("rstmid b1", 4'b0010, 8'h61);
        tick();
        rst = 1'b1;
        chk_idle("rstmid during");
        tick();
        rst = 1'b0;
        chk_idle("rstmid after");
        tick();
        chk_beat("rstmid prio", 4'b0001, 8'h70);
        req_valid = 4'b0000;
        tick();
        tick();
        chk_idle("rstmid end");

        // Sticky overflow error
        chk("err before", 32'(err), 32'd0);
        fifo_overflow = 1'b1;
        tick();
        fifo_overflow = 1'b0;
        chk("err set", 32'(err), 32'd1);
        tick();
        tick();
        tick();
        chk("err sticky", 32'(err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err cleared", 32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
